// File: rtl/regfile_writeback_queue_pkg.sv
// Shared widths for the register-file write path.
// WB_DEPTH sets the default writeback queue depth.
// No logic lives here.
package regfile_writeback_queue_pkg;
    localparam int DATA_LEN     = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int WB_DEPTH     = 4;
endpackage

// File: rtl/regfile_writeback_queue.sv
// Buffers result writes and drains one per cycle into the register file; forwarding built only with WB_FORWARD_EN.
// Latency: accept at edge N into an empty queue -> rf_we high after edge N+1.
// Backpressure: in_ready drops only when all DEPTH entries are occupied.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = DATA_LEN,
    parameter int ADDR_W = REG_ADDR_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_waddr,
    input  logic [DATA_W-1:0]          in_wdata,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    input  logic [ADDR_W-1:0]          fwd_raddr1,
    output logic                       fwd_hit1,
    output logic [DATA_W-1:0]          fwd_data1,
    input  logic [ADDR_W-1:0]          fwd_raddr2,
    output logic                       fwd_hit2,
    output logic [DATA_W-1:0]          fwd_data2,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push;
    logic              pop;

    assign in_ready = (count != CNT_W'(DEPTH));
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push     = in_valid && in_ready && (in_waddr != '0);
    assign pop      = (count != '0);
    assign busy     = pop || rf_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rf_waddr <= mem_addr[rd_ptr];
                rf_wdata <= mem_data[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_waddr;
            mem_data[wr_ptr] <= in_wdata;
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match (tail side) wins; output stage is oldest.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] raddr);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = '0;
        if (raddr != '0) begin
            if (rf_we && (rf_waddr == raddr)) begin
                res = {1'b1, rf_wdata};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if ((CNT_W'(i) < count) && (mem_addr[idx] == raddr)) begin
                    res = {1'b1, mem_data[idx]};
                end
            end
        end
        return res;
    endfunction

    logic [DATA_W:0] fwd1;
    logic [DATA_W:0] fwd2;

    always_comb begin
        fwd1 = lookup(fwd_raddr1);
        fwd2 = lookup(fwd_raddr2);
    end

    assign {fwd_hit1, fwd_data1} = fwd1;
    assign {fwd_hit2, fwd_data2} = fwd2;
`else
    logic unused_fwd_raddr;
    assign unused_fwd_raddr = ^{fwd_raddr1, fwd_raddr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data2 = '0;
`endif

endmodule
